// File: rtl/alu_req_scheduler.sv
// Round-robin scheduler sharing one combinational ALU among NUM_REQ requesters.
// Registers the granted operation into the ALU inputs and returns the result on a valid/ready channel.
module alu_req_scheduler #(
   parameter int WIDTH   = 128,
   parameter int NUM_REQ = 4,
   parameter int MUL_LAT = 3
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [NUM_REQ-1:0]           req_valid,
   output logic [NUM_REQ-1:0]           req_ready,
   input  logic [4*NUM_REQ-1:0]         req_opcode,
   input  logic [WIDTH*NUM_REQ-1:0]     req_a,
   input  logic [WIDTH*NUM_REQ-1:0]     req_b,
   input  logic [5*NUM_REQ-1:0]         req_shift,
   output logic [3:0]                   alu_opcode,
   output logic [WIDTH-1:0]             alu_in1,
   output logic [WIDTH-1:0]             alu_in2,
   output logic [4:0]                   alu_shift,
   input  logic [WIDTH-1:0]             alu_result,
   output logic                         rsp_valid,
   input  logic                         rsp_ready,
   output logic [$clog2(NUM_REQ)-1:0]   rsp_id,
   output logic [WIDTH-1:0]             rsp_result,
   output logic                         rsp_err
);
   localparam int IDW = $clog2(NUM_REQ);
   localparam logic [3:0] OP_MUL = 4'd5;
   localparam logic [3:0] OP_SEQ = 4'd6;
   localparam logic [3:0] OP_MAX = 4'd8;

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t                  state_q, state_d;
   logic [IDW-1:0]          rr_ptr_q, rr_ptr_d, id_q, id_d, rsp_id_q, rsp_id_d;
   logic [3:0]              cnt_q, cnt_d, op_q, op_d;
   logic [WIDTH-1:0]        in1_q, in1_d, in2_q, in2_d, res_q, res_d;
   logic [4:0]              sh_q, sh_d;
   logic                    rv_q, rv_d, err_q, err_d;
   logic                    gnt_any;
   logic [IDW-1:0]          gnt_id, idx;
   logic [IDW:0]            sum;

   logic [NUM_REQ-1:0][3:0]       op_v;
   logic [NUM_REQ-1:0][WIDTH-1:0] a_v, b_v;
   logic [NUM_REQ-1:0][4:0]       sh_v;

   assign op_v = req_opcode;
   assign a_v  = req_a;
   assign b_v  = req_b;
   assign sh_v = req_shift;

   // Scan from the farthest offset down so the requester closest to rr_ptr wins.
   always_comb begin
      gnt_any = 1'b0;
      gnt_id  = '0;
      sum     = '0;
      idx     = '0;
      for (int k = NUM_REQ-1; k >= 0; k--) begin
         sum = {1'b0, rr_ptr_q} + (IDW+1)'(k);
         if (sum >= (IDW+1)'(NUM_REQ)) sum = sum - (IDW+1)'(NUM_REQ);
         idx = sum[IDW-1:0];
         if (req_valid[idx]) begin
            gnt_any = 1'b1;
            gnt_id  = idx;
         end
      end
   end

   assign req_ready = (rst_n && state_q == IDLE && gnt_any) ? (NUM_REQ'(1) << gnt_id) : '0;

   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      id_d     = id_q;
      cnt_d    = cnt_q;
      op_d     = op_q;
      in1_d    = in1_q;
      in2_d    = in2_q;
      sh_d     = sh_q;
      rv_d     = rv_q;
      rsp_id_d = rsp_id_q;
      res_d    = res_q;
      err_d    = err_q;
      case (state_q)
         IDLE: begin
            if (gnt_any) begin
               op_d    = op_v[gnt_id];
               in1_d   = a_v[gnt_id];
               in2_d   = b_v[gnt_id];
               sh_d    = sh_v[gnt_id];
               id_d    = gnt_id;
               cnt_d   = (op_v[gnt_id] == OP_MUL) ? 4'(MUL_LAT-1) : 4'd0;
               state_d = EXEC;
            end
         end
         EXEC: begin
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               rv_d     = 1'b1;
               rsp_id_d = id_q;
               state_d  = RESP;
               // SEQ is resolved here; the shared ALU's output for it is not used.
               if (op_q > OP_MAX) begin
                  res_d = '0;
                  err_d = 1'b1;
               end else if (op_q == OP_SEQ) begin
                  res_d = {{(WIDTH-1){1'b0}}, (in1_q == in2_q)};
                  err_d = 1'b0;
               end else begin
                  res_d = alu_result;
                  err_d = 1'b0;
               end
            end
         end
         RESP: begin
            if (rsp_ready) begin
               rv_d     = 1'b0;
               rr_ptr_d = (id_q == IDW'(NUM_REQ-1)) ? '0 : id_q + 1'b1;
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         rr_ptr_q <= '0;
         id_q     <= '0;
         cnt_q    <= '0;
         op_q     <= '0;
         in1_q    <= '0;
         in2_q    <= '0;
         sh_q     <= '0;
         rv_q     <= 1'b0;
         rsp_id_q <= '0;
         res_q    <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         id_q     <= id_d;
         cnt_q    <= cnt_d;
         op_q     <= op_d;
         in1_q    <= in1_d;
         in2_q    <= in2_d;
         sh_q     <= sh_d;
         rv_q     <= rv_d;
         rsp_id_q <= rsp_id_d;
         res_q    <= res_d;
         err_q    <= err_d;
      end
   end

   assign alu_opcode = op_q;
   assign alu_in1    = in1_q;
   assign alu_in2    = in2_q;
   assign alu_shift  = sh_q;
   assign rsp_valid  = rv_q;
   assign rsp_id     = rsp_id_q;
   assign rsp_result = res_q;
   assign rsp_err    = err_q;
endmodule

// File: tb/tb_alu_req_scheduler.sv
// Self-checking bench for alu_req_scheduler: vector table, response scoreboard,
// and hand-written sequences for arbitration, backpressure and mid-operation reset.
module tb_alu_req_scheduler;
   localparam int W = 128;
   localparam int N = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [N-1:0]   req_valid, req_ready;
   logic [4*N-1:0] req_opcode;
   logic [W*N-1:0] req_a, req_b;
   logic [5*N-1:0] req_shift;
   logic [3:0]     alu_opcode;
   logic [W-1:0]   alu_in1, alu_in2, alu_result, rsp_result;
   logic [4:0]     alu_shift;
   logic           rsp_valid, rsp_ready, rsp_err;
   logic [1:0]     rsp_id;

   alu_req_scheduler #(.WIDTH(W), .NUM_REQ(N), .MUL_LAT(3)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
      .req_a(req_a), .req_b(req_b), .req_shift(req_shift),
      .alu_opcode(alu_opcode), .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_shift(alu_shift),
      .alu_result(alu_result),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_result(rsp_result), .rsp_err(rsp_err)
   );

   // External ALU; SEQ and undefined opcodes return junk the scheduler must not forward.
   always_comb begin
      case (alu_opcode)
         4'd0:    alu_result = alu_in1 + alu_in2;
         4'd1:    alu_result = alu_in1 - alu_in2;
         4'd2:    alu_result = alu_in1 & alu_in2;
         4'd3:    alu_result = alu_in1 | alu_in2;
         4'd4:    alu_result = alu_in1 << alu_shift;
         4'd5:    alu_result = alu_in1 * alu_in2;
         4'd6:    alu_result = W'(128'hBAD);
         4'd7:    alu_result = alu_in1 >> alu_shift;
         4'd8:    alu_result = alu_in2;
         default: alu_result = '1;
      endcase
   end

   typedef struct {
      int           id;
      logic [3:0]   op;
      logic [W-1:0] a, b;
      logic [4:0]   sh;
      logic [W-1:0] res;
      logic         err;
      int           lat;
   } vec_t;

   typedef struct {
      int           id;
      logic [W-1:0] res;
      logic         err;
   } exp_t;

   exp_t sb[$];
   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int id, input logic [3:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [4:0] sh);
      req_opcode[4*id +: 4] = op;
      req_a[W*id +: W]      = a;
      req_b[W*id +: W]      = b;
      req_shift[5*id +: 5]  = sh;
   endtask

   task automatic pop_cmp(input string nm);
      exp_t e;
      n_chk++;
      if (sb.size() == 0) begin
         n_fail++;
         $display("FAIL %s: response id %0d with empty scoreboard", nm, rsp_id);
      end else begin
         e = sb.pop_front();
         chk({nm, "_id"}, W'(rsp_id), W'(e.id));
         chk({nm, "_res"}, rsp_result, e.res);
         chk({nm, "_err"}, W'(rsp_err), W'(e.err));
      end
   endtask

   task automatic wait_rsp(input string nm, inout int lat);
      int lim;
      lim = lat + 40;
      while (!rsp_valid && lat < lim) begin
         tick;
         lat++;
      end
      if (!rsp_valid) begin
         n_chk++;
         n_fail++;
         $display("FAIL %s_timeout: no rsp_valid after %0d cycles", nm, lat);
      end
   endtask

   task automatic run_op(input vec_t v);
      int lat;
      req_valid = '0;
      set_req(v.id, v.op, v.a, v.b, v.sh);
      req_valid[v.id] = 1'b1;
      #1;
      chk("grant", W'(req_ready), W'(1) << v.id);
      sb.push_back('{v.id, v.res, v.err});
      tick;
      req_valid = '0;
      chk("alu_opcode_c1", W'(alu_opcode), W'(v.op));
      chk("alu_in1_c1", alu_in1, v.a);
      lat = 1;
      wait_rsp("op", lat);
      chk("latency", W'(lat), W'(v.lat));
      chk("alu_opcode_held", W'(alu_opcode), W'(v.op));
      pop_cmp("op");
      tick;
   endtask

   vec_t tbl[11];
   int   gid[$];
   int   gcyc[$];
   int   lat;
   logic [W-1:0] held;

   initial begin
      tbl[0]  = '{0, 4'd0, W'(5),        W'(7),    5'd0, W'(12),          1'b0, 2};
      tbl[1]  = '{1, 4'd1, W'(0),        W'(1),    5'd0, '1,              1'b0, 2};
      tbl[2]  = '{2, 4'd5, W'(1) << 64,  W'(3),    5'd0, W'(3) << 64,     1'b0, 4};
      tbl[3]  = '{3, 4'd6, W'(9),        W'(9),    5'd0, W'(1),           1'b0, 2};
      tbl[4]  = '{0, 4'd6, W'(9),        W'(8),    5'd0, W'(0),           1'b0, 2};
      tbl[5]  = '{1, 4'd9, W'(9),        W'(8),    5'd0, W'(0),           1'b1, 2};
      tbl[6]  = '{2, 4'd2, W'(16'hF0F0), W'(16'h3C3C), 5'd0, W'(16'h3030), 1'b0, 2};
      tbl[7]  = '{3, 4'd3, W'(16'hF000), W'(16'h000F), 5'd0, W'(16'hF00F), 1'b0, 2};
      tbl[8]  = '{0, 4'd4, W'(1),        W'(0),    5'd4, W'(16),          1'b0, 2};
      tbl[9]  = '{1, 4'd7, W'(256),      W'(0),    5'd4, W'(16),          1'b0, 2};
      tbl[10] = '{2, 4'd8, W'(3),        W'(77),   5'd0, W'(77),          1'b0, 2};

      req_valid  = '1;
      req_opcode = '0;
      req_a      = '0;
      req_b      = '0;
      req_shift  = '0;
      rsp_ready  = 1'b0;
      #12;
      chk("rst_req_ready", W'(req_ready), W'(0));
      chk("rst_alu_opcode", W'(alu_opcode), W'(0));
      chk("rst_alu_in1", alu_in1, W'(0));
      chk("rst_rsp_valid", W'(rsp_valid), W'(0));
      chk("rst_rsp_result", rsp_result, W'(0));
      req_valid = '0;
      tick;
      rst_n = 1'b1;
      rsp_ready = 1'b1;
      tick;

      for (int i = 0; i < 11; i++) run_op(tbl[i]);

      // Reset in the middle of a req3 MUL; the operation must vanish.
      set_req(3, 4'd5, W'(6), W'(7), 5'd0);
      set_req(0, 4'd0, W'(0), W'(10), 5'd0);
      req_valid = 4'b1000;
      #1;
      chk("mul3_grant", W'(req_ready), W'(4'b1000));
      tick;
      req_valid = 4'b1001;
      tick;
      chk("mul3_in_exec", W'(alu_opcode), W'(5));
      rst_n = 1'b0;
      #1;
      chk("midrst_alu_opcode", W'(alu_opcode), W'(0));
      chk("midrst_alu_in1", alu_in1, W'(0));
      chk("midrst_rsp_valid", W'(rsp_valid), W'(0));
      chk("midrst_req_ready", W'(req_ready), W'(0));
      tick;
      rst_n = 1'b1;
      #1;
      chk("postrst_grant", W'(req_ready), W'(4'b0001));

      // All four valid: grants 0,1,2,3,0 every third cycle.
      for (int i = 0; i < N; i++) set_req(i, 4'd0, W'(i), W'(10), 5'd0);
      req_valid = 4'b1111;
      #1;
      for (int c = 0; c < 15; c++) begin
         for (int i = 0; i < N; i++) begin
            if (req_ready[i]) begin
               gid.push_back(i);
               gcyc.push_back(c);
               sb.push_back('{i, W'(i + 10), 1'b0});
            end
         end
         if (rsp_valid) pop_cmp("rr");
         tick;
      end
      req_valid = '0;
      chk("rr_ngrants", W'(gid.size()), W'(5));
      for (int k = 0; k < 5 && k < gid.size(); k++) begin
         chk("rr_order", W'(gid[k]), W'(k % 4));
         chk("rr_cycle", W'(gcyc[k]), W'(3 * k));
      end

      // Backpressure: response held for 5 cycles; req0 waits behind it.
      rsp_ready = 1'b0;
      set_req(1, 4'd0, W'(3), W'(4), 5'd0);
      req_valid = 4'b0010;
      #1;
      chk("bp_grant", W'(req_ready), W'(4'b0010));
      sb.push_back('{1, W'(7), 1'b0});
      tick;
      req_valid = 4'b0001;
      lat = 1;
      wait_rsp("bp", lat);
      held = rsp_result;
      for (int c = 0; c < 5; c++) begin
         chk("bp_valid", W'(rsp_valid), W'(1));
         chk("bp_stable", rsp_result, W'(7));
         chk("bp_ready", W'(req_ready), W'(0));
         tick;
      end
      rsp_ready = 1'b1;
      #1;
      chk("bp_still_blocked", W'(req_ready), W'(0));
      chk("bp_result_kept", rsp_result, held);
      pop_cmp("bp");
      tick;
      chk("bp_next_grant", W'(req_ready), W'(4'b0001));
      sb.push_back('{0, W'(10), 1'b0});
      tick;
      req_valid = '0;
      lat = 1;
      wait_rsp("bp2", lat);
      pop_cmp("bp2");
      tick;
      chk("sb_empty", W'(sb.size()), W'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
